// File: rtl/pseudo_spi_rd_intf_if.sv
// pseudo_spi_rd_intf_if: bus bundle between the scan read-back controller and its environment.
//   BGN, ADDR_BGN, DATA_LEN, SPI_SI      : start level, first SRAM address, word count, serial scan-out
//   SCLK1, SCLK2, SEL                    : two-phase scan clocks and select strobe to the analog chain
//   A, PO, CEN, D_WE                     : SRAM write port (CEN/D_WE active low)
//   spi_MUX, spi_is_done                 : SRAM bus ownership and transfer-complete flag
interface pseudo_spi_rd_intf_if #(
    parameter int MEMORY_DATA_WIDTH = 8,
    parameter int MEMORY_ADDR_WIDTH = 10,
    parameter int RESERVED_DATA_LEN = 8
);
    logic                         BGN;
    logic [MEMORY_ADDR_WIDTH-1:0] ADDR_BGN;
    logic [RESERVED_DATA_LEN-1:0] DATA_LEN;
    logic                         SPI_SI;
    logic                         SCLK1;
    logic                         SCLK2;
    logic                         SEL;
    logic [MEMORY_ADDR_WIDTH-1:0] A;
    logic [MEMORY_DATA_WIDTH-1:0] PO;
    logic                         CEN;
    logic                         D_WE;
    logic                         spi_MUX;
    logic                         spi_is_done;

    modport master (
        output BGN, ADDR_BGN, DATA_LEN, SPI_SI,
        input  SCLK1, SCLK2, SEL, A, PO, CEN, D_WE, spi_MUX, spi_is_done
    );

    modport slave (
        input  BGN, ADDR_BGN, DATA_LEN, SPI_SI,
        output SCLK1, SCLK2, SEL, A, PO, CEN, D_WE, spi_MUX, spi_is_done
    );
endinterface

// File: rtl/pseudo_spi_rd_intf.sv
// pseudo_spi_rd_intf: drives two-phase scan clocks, captures scan-out LSB-first into words, writes them to SRAM.
//   CLK  : clock, posedge
//   RSTN : asynchronous active-low reset
//   bus  : slave side of pseudo_spi_rd_intf_if (start/length/serial in, scan clocks and SRAM write port out)
module pseudo_spi_rd_intf #(
    parameter int MEMORY_DATA_WIDTH = 8,
    parameter int MEMORY_ADDR_WIDTH = 10,
    parameter int RESERVED_DATA_LEN = 8
) (
    input logic                 CLK,
    input logic                 RSTN,
    pseudo_spi_rd_intf_if.slave bus
);
    localparam int W  = MEMORY_DATA_WIDTH;
    localparam int AW = MEMORY_ADDR_WIDTH;
    localparam int RL = RESERVED_DATA_LEN;
    localparam int BW = (W > 1) ? $clog2(W) : 1;

    typedef enum logic [2:0] {S_IDLE, S_SEL, S_SHIFT, S_WRITE, S_DONE} state_t;

    state_t          state_q, state_d;
    logic [1:0]      ph_q, ph_d;
    logic [BW-1:0]   bit_q, bit_d;
    logic [AW-1:0]   addr_q, addr_d;
    logic [RL-1:0]   cnt_q, cnt_d;
    logic [W-1:0]    sreg_q, sreg_d;
    logic            sclk1_q, sclk2_q, sel_q, cen_q, mux_q, done_q;

    always_comb begin
        state_d = state_q;
        ph_d    = ph_q;
        bit_d   = bit_q;
        addr_d  = addr_q;
        cnt_d   = cnt_q;
        sreg_d  = sreg_q;
        case (state_q)
            S_IDLE: if (bus.BGN) begin
                state_d = S_SEL;
                ph_d    = 2'd0;
                addr_d  = bus.ADDR_BGN;
                cnt_d   = bus.DATA_LEN;
            end
            // ph_q doubles as the 2-cycle SEL timer
            S_SEL: if (!bus.BGN) state_d = S_IDLE;
            else if (ph_q[0]) begin
                state_d = (cnt_q == '0) ? S_DONE : S_SHIFT;
                ph_d    = 2'd0;
                bit_d   = '0;
            end else ph_d = 2'd1;
            S_SHIFT: if (!bus.BGN) state_d = S_IDLE;
            else begin
                ph_d = ph_q + 2'd1;
                if (ph_q == 2'd3) begin
                    sreg_d  = {bus.SPI_SI, sreg_q[W-1:1]};
                    bit_d   = bit_q + 1'b1;
                    state_d = (bit_q == BW'(W - 1)) ? S_WRITE : S_SHIFT;
                end
            end
            S_WRITE: if (!bus.BGN) state_d = S_IDLE;
            else begin
                addr_d  = addr_q + 1'b1;
                cnt_d   = cnt_q - 1'b1;
                ph_d    = 2'd0;
                bit_d   = '0;
                state_d = (cnt_q == RL'(1)) ? S_DONE : S_SHIFT;
            end
            S_DONE: if (!bus.BGN) state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // Control outputs are registered from the next state so they line up with the state they describe.
    always_ff @(posedge CLK or negedge RSTN) begin
        if (!RSTN) begin
            state_q <= S_IDLE;
            ph_q    <= '0;
            bit_q   <= '0;
            addr_q  <= '0;
            cnt_q   <= '0;
            sreg_q  <= '0;
            sclk1_q <= 1'b0;
            sclk2_q <= 1'b0;
            sel_q   <= 1'b0;
            cen_q   <= 1'b1;
            mux_q   <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            ph_q    <= ph_d;
            bit_q   <= bit_d;
            addr_q  <= addr_d;
            cnt_q   <= cnt_d;
            sreg_q  <= sreg_d;
            sclk1_q <= (state_d == S_SHIFT) && (ph_d == 2'd0);
            sclk2_q <= (state_d == S_SHIFT) && (ph_d == 2'd2);
            sel_q   <= state_d == S_SEL;
            cen_q   <= state_d != S_WRITE;
            mux_q   <= state_d inside {S_SEL, S_SHIFT, S_WRITE};
            done_q  <= state_d == S_DONE;
        end
    end

    assign bus.SCLK1       = sclk1_q;
    assign bus.SCLK2       = sclk2_q;
    assign bus.SEL         = sel_q;
    assign bus.A           = addr_q;
    assign bus.PO          = sreg_q;
    assign bus.CEN         = cen_q;
    assign bus.D_WE        = cen_q;
    assign bus.spi_MUX     = mux_q;
    assign bus.spi_is_done = done_q;
endmodule

// File: tb/tb_pseudo_spi_rd_intf.sv
// tb_pseudo_spi_rd_intf: randomized scenario bench for pseudo_spi_rd_intf against a cycle-schedule model.
module tb_pseudo_spi_rd_intf;
    localparam int W  = 8;
    localparam int AW = 10;
    localparam int RL = 8;
    localparam int P  = 4 * W + 1;

    logic CLK  = 1'b0;
    logic RSTN = 1'b0;

    pseudo_spi_rd_intf_if #(.MEMORY_DATA_WIDTH(W), .MEMORY_ADDR_WIDTH(AW), .RESERVED_DATA_LEN(RL)) bus();

    pseudo_spi_rd_intf #(.MEMORY_DATA_WIDTH(W), .MEMORY_ADDR_WIDTH(AW), .RESERVED_DATA_LEN(RL)) dut (
        .CLK (CLK),
        .RSTN(RSTN),
        .bus (bus)
    );

    always #5 CLK = ~CLK;

    int vec    = 0;
    int miscmp = 0;

    logic [W-1:0]  wq[$];
    int            wr_cyc[$];
    logic [AW-1:0] wr_a[$];
    logic [W-1:0]  wr_d[$];
    int s1, s2, ov, sel_n, sel_first, done_first, mux_n, we_n;
    logic done_last;

    // Runs one transfer for `cycles` clocks after the start edge t0, logging what the DUT does.
    // m is the number of posedges since t0 (m=0 samples the cycle right after t0).
    task automatic go(input logic [AW-1:0] a, input int n, input int cycles, input int abort_m);
        logic [W-1:0] w;
        int e;
        s1 = 0; s2 = 0; ov = 0; sel_n = 0; sel_first = -1; done_first = -1; mux_n = 0; we_n = 0;
        wr_cyc.delete(); wr_a.delete(); wr_d.delete();
        bus.ADDR_BGN = a;
        bus.DATA_LEN = RL'(n);
        bus.BGN      = 1'b1;
        for (int m = 0; m < cycles; m++) begin
            @(posedge CLK); #1;
            if (bus.SCLK1) s1++;
            if (bus.SCLK2) s2++;
            if (bus.SCLK1 && bus.SCLK2) ov++;
            if (bus.SEL) begin
                sel_n++;
                if (sel_first < 0) sel_first = m;
            end
            if (bus.spi_MUX) mux_n++;
            if (!bus.D_WE) we_n++;
            if (!bus.CEN) begin
                wr_cyc.push_back(m);
                wr_a.push_back(bus.A);
                wr_d.push_back(bus.PO);
            end
            if (bus.spi_is_done && done_first < 0) done_first = m;
            done_last = bus.spi_is_done;
            if (m == abort_m) bus.BGN = 1'b0;
            bus.ADDR_BGN = AW'($urandom);
            bus.DATA_LEN = RL'($urandom);
            // Bit j of word k is sampled at edge t0+2+k*P+4(j+1); other edges see noise.
            e = m - 1;
            bus.SPI_SI = 1'($urandom);
            if (e >= 0 && (e % P) >= 4 && (e % P) % 4 == 0 && e / P < wq.size()) begin
                w = wq[e / P];
                bus.SPI_SI = w[(e % P) / 4 - 1];
            end
        end
    endtask

    task automatic test_reset;
        @(posedge CLK); #1;
        vec++;
        if ({bus.SCLK1, bus.SCLK2, bus.SEL, bus.CEN, bus.D_WE, bus.spi_MUX, bus.spi_is_done} !== 7'b0001100
            || bus.A !== '0 || bus.PO !== '0) begin
            miscmp++;
            $display("FAIL reset_values: ctl=%b A=%h PO=%h want ctl=0001100 A=0 PO=0",
                {bus.SCLK1, bus.SCLK2, bus.SEL, bus.CEN, bus.D_WE, bus.spi_MUX, bus.spi_is_done}, bus.A, bus.PO);
        end
        RSTN = 1'b1;
        @(posedge CLK); #1;
    endtask

    task automatic test_xfer(input string nm, input logic [AW-1:0] a, input int n);
        logic [AW-1:0] ea;
        go(a, n, 2 + n * P + 6, -1);
        vec++;
        if (wr_cyc.size() != n) begin
            miscmp++;
            $display("FAIL %s write_count: got %0d want %0d", nm, wr_cyc.size(), n);
        end
        for (int k = 0; k < n && k < wr_cyc.size(); k++) begin
            ea = a + AW'(k);
            vec++;
            if (wr_a[k] !== ea || wr_d[k] !== wq[k] || wr_cyc[k] != 2 + k * P + 4 * W) begin
                miscmp++;
                $display("FAIL %s write%0d: got A=%h PO=%h at %0d want A=%h PO=%h at %0d",
                    nm, k, wr_a[k], wr_d[k], wr_cyc[k], ea, wq[k], 2 + k * P + 4 * W);
            end
        end
        vec++;
        if (s1 != n * W || s2 != n * W || ov != 0) begin
            miscmp++;
            $display("FAIL %s sclk: got s1=%0d s2=%0d overlap=%0d want %0d %0d 0", nm, s1, s2, ov, n * W, n * W);
        end
        vec++;
        if (sel_n != 2 || sel_first != 0) begin
            miscmp++;
            $display("FAIL %s sel: got %0d cycles from %0d want 2 from 0", nm, sel_n, sel_first);
        end
        vec++;
        if (done_first != 2 + n * P || done_last !== 1'b1) begin
            miscmp++;
            $display("FAIL %s done: got rise %0d held %b want rise %0d held 1", nm, done_first, done_last, 2 + n * P);
        end
        vec++;
        if (mux_n != 2 + n * P || we_n != n) begin
            miscmp++;
            $display("FAIL %s mux_we: got mux=%0d we=%0d want %0d %0d", nm, mux_n, we_n, 2 + n * P, n);
        end
        bus.BGN = 1'b0;
        @(posedge CLK); #1;
        vec++;
        if (bus.spi_is_done !== 1'b0 || bus.spi_MUX !== 1'b0) begin
            miscmp++;
            $display("FAIL %s release: got done=%b mux=%b want 0 0", nm, bus.spi_is_done, bus.spi_MUX);
        end
        @(posedge CLK); #1;
    endtask

    task automatic test_single;
        wq.delete(); wq.push_back(8'hA5);
        test_xfer("single", 10'h010, 1);
    endtask

    task automatic test_wrap;
        wq.delete(); wq.push_back(8'h3C); wq.push_back(8'hC3);
        test_xfer("wrap", 10'h3FF, 2);
    endtask

    task automatic test_zero;
        wq.delete();
        test_xfer("zero", AW'($urandom), 0);
    endtask

    task automatic test_random;
        int n;
        for (int i = 0; i < 4; i++) begin
            n = $urandom_range(1, 3);
            wq.delete();
            for (int k = 0; k < n; k++) wq.push_back(W'($urandom));
            test_xfer("random", AW'($urandom), n);
        end
    endtask

    task automatic test_abort;
        logic [AW-1:0] a;
        a = AW'($urandom);
        wq.delete();
        for (int k = 0; k < 3; k++) wq.push_back(W'($urandom));
        // bit 5 of word 1 starts at m = 2 + P + 20
        go(a, 3, 70, 2 + P + 21);
        vec++;
        if (wr_cyc.size() != 1 || wr_a[0] !== a || wr_d[0] !== wq[0]) begin
            miscmp++;
            $display("FAIL abort_writes: got %0d writes first A=%h PO=%h want 1 A=%h PO=%h",
                wr_cyc.size(), wr_a[0], wr_d[0], a, wq[0]);
        end
        vec++;
        if (done_first != -1 || mux_n != 2 + P + 22 || s1 != W + 6 || s2 != W + 5) begin
            miscmp++;
            $display("FAIL abort_stop: got done=%0d mux=%0d s1=%0d s2=%0d want -1 %0d %0d %0d",
                done_first, mux_n, s1, s2, 2 + P + 22, W + 6, W + 5);
        end
        wq.delete(); wq.push_back(W'($urandom)); wq.push_back(W'($urandom));
        test_xfer("restart", AW'($urandom), 2);
    endtask

    task automatic test_reset_mid;
        int act;
        wq.delete(); wq.push_back(W'($urandom)); wq.push_back(W'($urandom));
        go(AW'($urandom), 2, 4 * W + 3, -1);
        vec++;
        if (wr_cyc.size() != 1) begin
            miscmp++;
            $display("FAIL rstmid_in_write: got %0d writes want 1", wr_cyc.size());
        end
        RSTN = 1'b0;
        #2;
        vec++;
        if ({bus.SCLK1, bus.SCLK2, bus.SEL, bus.CEN, bus.D_WE, bus.spi_MUX, bus.spi_is_done} !== 7'b0001100
            || bus.A !== '0 || bus.PO !== '0) begin
            miscmp++;
            $display("FAIL rstmid_async: ctl=%b A=%h PO=%h want ctl=0001100 A=0 PO=0",
                {bus.SCLK1, bus.SCLK2, bus.SEL, bus.CEN, bus.D_WE, bus.spi_MUX, bus.spi_is_done}, bus.A, bus.PO);
        end
        bus.BGN = 1'b0;
        @(posedge CLK); @(posedge CLK); #1;
        RSTN = 1'b1;
        act = 0;
        for (int m = 0; m < 40; m++) begin
            @(posedge CLK); #1;
            if (!bus.CEN || !bus.D_WE || bus.spi_MUX || bus.SCLK1) act++;
        end
        vec++;
        if (act != 0) begin
            miscmp++;
            $display("FAIL rstmid_quiet: got %0d active cycles want 0", act);
        end
        wq.delete(); wq.push_back(W'($urandom));
        test_xfer("post_reset", AW'($urandom), 1);
    endtask

    initial begin
        bus.BGN      = 1'b0;
        bus.ADDR_BGN = '0;
        bus.DATA_LEN = '0;
        bus.SPI_SI   = 1'b0;
        test_reset;
        test_single;
        test_wrap;
        test_zero;
        test_random;
        test_abort;
        test_reset_mid;
        $display("== %0d vectors applied, %0d miscompares ==", vec, miscmp);
        $finish;
    end
endmodule
